rr_req_arbiter: RTL and testbench

Round-robin request arbiter that captures pulsed request lines into sticky pending bits and issues one registered one-hot grant at a time over a valid/ready handshake. It sits directly upstream of the N-to-log2(N) encoder. The encoder's `x` input is driven by `grant`, and its `en` input is driven by `valid`. The arbiter guarantees that `x` is always exactly one-hot or zero.

---
 rtl/rr_req_arbiter_pkg.sv | 27 ++
 rtl/rr_req_arbiter_pick.sv | 64 ++++++
 rtl/rr_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_rr_req_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_req_arbiter_pkg.sv
// Shared definitions for the round-robin request arbiter: FSM state type,
// a constant-foldable ceil(log2) helper, and the default requester count
// that the downstream encoder bench also uses.
package arb_pkg;

    // Default number of requesters (grant width)
    localparam int ARB_N_DEFAULT = 8;

    // Two-state grant FSM: IDLE has no live grant, BUSY holds one
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2, never below 1 so a pointer always has at least one bit
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// Combinational round-robin selector. Candidates are rotated so the slot
// after the pointer sits at position 0, the lowest set bit is taken, and the
// winning position is rotated back to an absolute index and one-hot vector.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = ARB_N_DEFAULT,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [PW-1:0] sel_idx,
    output logic          any
);

    logic [PW-1:0] start;
    logic [N-1:0]  rot;
    logic [PW-1:0] pos;
    logic          found;
    logic [PW-1:0] idx;

    // Search origin is ptr+1 modulo N; out-of-range pointers fold to 0
    always_comb begin
        if (int'(ptr) >= N - 1) begin
            start = '0;
        end else begin
            start = ptr + 1'b1;
        end
    end

    // Rotate candidates so the search origin becomes bit 0
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = cand[PW'((i + int'(start)) % N)];
        end
    end

    // Fixed priority: lowest rotated position wins
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = PW'(i);
            end
        end
    end

    // Rotate the winner back to its absolute index and one-hot form
    always_comb begin
        idx = PW'((int'(pos) + int'(start)) % N);
        sel = '0;
        if (found) begin
            sel[idx] = 1'b1;
        end
    end

    assign sel_idx = idx;
    assign any     = found;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter. Pulsed requests are captured into sticky
// pending bits; one registered one-hot grant is offered at a time over a
// valid/ready handshake, with back-to-back grants at full throughput.
// Grant and valid come straight from flops, so ready never reaches them
// combinationally.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         ready,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic [N-1:0] pending
);

    localparam int PW = clog2(N);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pending_q, pending_d;

    logic [N-1:0]  cand;
    logic          accept;
    logic [N-1:0]  clr;
    logic [N-1:0]  pick_cand;
    logic [PW-1:0] pick_ptr;
    logic [N-1:0]  pick_sel;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    // New requests are eligible in the cycle they arrive
    assign cand   = pending_q | req;
    assign accept = (state_q == BUSY) && ready;
    assign clr    = accept ? grant_q : '0;

    // A request arriving on the accepting edge re-arms its bit (set beats clear)
    assign pending_d = (pending_q & ~clr) | req;

    // While BUSY the only pick that matters is the back-to-back one, which
    // searches from the grant being accepted and excludes it
    always_comb begin
        if (state_q == BUSY) begin
            pick_cand = cand & ~grant_q;
            pick_ptr  = gidx_q;
        end else begin
            pick_cand = cand;
            pick_ptr  = ptr_q;
        end
    end

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .cand    (pick_cand),
        .ptr     (pick_ptr),
        .sel     (pick_sel),
        .sel_idx (pick_idx),
        .any     (pick_any)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter/stay BUSY whenever a grant can be loaded
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ready) begin
                    if (en && pick_any) begin
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: next grant, its index, and the round-robin pointer
    always_comb begin
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    grant_d = pick_sel;
                    gidx_d  = pick_idx;
                end else begin
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (ready) begin
                    ptr_d = gidx_q;
                    if (en && pick_any) begin
                        grant_d = pick_sel;
                        gidx_d  = pick_idx;
                    end else begin
                        grant_d = '0;
                    end
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Grant, pointer and pending registers; reset restarts priority at index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= PW'(N - 1);
            pending_q <= '0;
        end else begin
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
        end
    end

    assign grant   = grant_q;
    assign valid   = (state_q == BUSY);
    assign pending = pending_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter (N=8) plus a randomized run with the
// grant feeding a behavioural N-to-log2(N) encoder.
module tb_rr_req_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         en;
    logic         ready;
    logic [N-1:0] grant;
    logic         valid;
    logic [N-1:0] pending;

    int total;
    int bad;
    logic [N-1:0] pend_exp;

    rr_req_arbiter #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (en),
        .ready   (ready),
        .grant   (grant),
        .valid   (valid),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        en    = 1'b0;
        ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Behavioural encoder: index of the set bit
    function automatic int enc(input logic [N-1:0] x);
        int y;
        y = 0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) y = i;
        end
        return y;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        en    = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_pending", pending, 8'h00);
        rst = 1'b0;

        // Reset mid-grant clears everything immediately
        req = 8'h01; en = 1'b1; ready = 1'b0;
        tick();
        chk("pre_rst_grant", grant, 8'h01);
        chk("pre_rst_valid", valid, 1'b1);
        req = 8'h00;
        rst = 1'b1;
        #2;
        chk("async_rst_grant", grant, 8'h00);
        chk("async_rst_valid", valid, 1'b0);
        chk("async_rst_pending", pending, 8'h00);
        tick();
        rst = 1'b0;

        // All requesting: rotation in index order, wrapping 7 -> 0
        req = 8'hFF; en = 1'b1; ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rotate_grant", grant, 8'h01 << (i % 8));
            chk("rotate_valid", valid, 1'b1);
        end

        // Hold: grant stable while ready=0
        do_reset();
        req = 8'h24; en = 1'b1; ready = 1'b0;
        tick();
        chk("hold_first", grant, 8'h04);
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_grant", grant, 8'h04);
            chk("hold_pending", pending, 8'h24);
        end
        ready = 1'b1;
        tick();
        chk("hold_next", grant, 8'h20);
        chk("hold_next_pend", pending, 8'h20);
        tick();
        chk("hold_idle_valid", valid, 1'b0);
        chk("hold_idle_grant", grant, 8'h00);
        chk("hold_idle_pend", pending, 8'h00);

        // Enable gating: no grant while en=0, pending still captures
        do_reset();
        req = 8'h81; en = 1'b0; ready = 1'b1;
        tick();
        chk("en0_valid", valid, 1'b0);
        chk("en0_pending", pending, 8'h81);
        req = 8'h00;
        tick();
        chk("en0_valid2", valid, 1'b0);
        chk("en0_grant2", grant, 8'h00);
        en = 1'b1;
        tick();
        chk("en1_grant_a", grant, 8'h01);
        tick();
        chk("en1_grant_b", grant, 8'h80);
        tick();
        chk("en1_idle", valid, 1'b0);

        // Wrap fairness: last grant index 6, index 7 empty, wraps to 0
        do_reset();
        req = 8'h40; en = 1'b1; ready = 1'b1;
        tick();
        chk("wrap_setup", grant, 8'h40);
        req = 8'h41;
        tick();
        chk("wrap_to0", grant, 8'h01);
        tick();
        chk("wrap_back6", grant, 8'h40);
        req = 8'h00;
        tick();
        chk("wrap_rearm", grant, 8'h01);
        tick();
        chk("wrap_idle", valid, 1'b0);

        // Set-over-clear: bit 3 re-requested on its own accepting edge
        do_reset();
        req = 8'h0A; en = 1'b1; ready = 1'b0;
        tick();
        chk("soc_first", grant, 8'h02);
        chk("soc_pend0", pending, 8'h0A);
        req = 8'h00; ready = 1'b1;
        tick();
        chk("soc_g3", grant, 8'h08);
        req = 8'h18;
        tick();
        chk("soc_pend_keep", pending, 8'h18);
        chk("soc_g4", grant, 8'h10);
        req = 8'h00;
        tick();
        chk("soc_regrant3", grant, 8'h08);
        tick();
        chk("soc_idle", valid, 1'b0);
        chk("soc_pend_clr", pending, 8'h00);

        // Encoder chain with random traffic
        do_reset();
        pend_exp = '0;
        for (int c = 0; c < 1000; c++) begin
            req   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            ready = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 7) != 0);
            pend_exp = (pend_exp & ~((valid && ready) ? grant : '0)) | req;
            tick();
            chk("chain_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
            chk("chain_enc", valid ? (32'd1 << enc(grant)) : 32'd0, {24'b0, grant});
            chk("chain_pending", pending, pend_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
